psum_accumulator: RTL

- Sits directly downstream of the ADDER tree and consumes its Psum/Psum_valid stream.
- Sums the per-round partial sums of one kernel window lane-wise. wsize sets the beat count: 3x3 → 1 beat, 5x5 → 2, 7x7 → 4.
- Widens results for headroom and presents each completed group on a valid/ready output register to the output writer.
- A completed group can be held while the next one accumulates; an overflow flag reports any beat that had to be dropped.

---
 rtl/psum_pkg.sv | 36 +++
 rtl/psum_lane_add.sv | 24 ++
 rtl/psum_accumulator.sv | 107 ++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared sizes, FSM encoding and kernel-size decode for the partial-sum accumulator.
// Optional ReLU on the output register is enabled with the PSUM_RELU_EN macro.
package psum_pkg;

    localparam int LANES = 48;
    localparam int PW    = 18;
    localparam int OW    = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] rounds;
        logic       illegal;
    } rounds_t;

    // Unknown kernel codes fall back to a single round and are flagged.
    function automatic rounds_t rounds_of(input logic [3:0] wsize);
        rounds_t r;
        r.illegal = 1'b0;
        case (wsize)
            4'd0:    r.rounds = 3'd1;
            4'd1:    r.rounds = 3'd2;
            4'd2:    r.rounds = 3'd4;
            default: begin
                r.rounds  = 3'd1;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psum_lane_add.sv
// One lane of the accumulator datapath: sign-extend, load-or-add, optional ReLU
// (PSUM_RELU_EN) on the value headed for the output register. Purely combinational.
module psum_lane_add
    import psum_pkg::*;
(
    input  logic [PW-1:0] psum,
    input  logic [OW-1:0] acc,
    input  logic          load,
    output logic [OW-1:0] sum,
    output logic [OW-1:0] out_val
);

    logic [OW-1:0] ext;

    assign ext = {{(OW-PW){psum[PW-1]}}, psum};
    assign sum = load ? ext : acc + ext;

`ifdef PSUM_RELU_EN
    assign out_val = sum[OW-1] ? '0 : sum;
`else
    assign out_val = sum;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates 1/2/4 Psum beats per kernel window lane-wise and hands each group to a
// valid/ready output register; build with PSUM_RELU_EN to clamp negative output lanes.
module psum_accumulator
    import psum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            wsize,
    input  logic                  Psum_valid,
    input  logic [LANES*PW-1:0]   Psum,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [LANES*OW-1:0]   out_data,
    output logic                  busy,
    output logic                  overflow,
    output logic                  bad_wsize
);

    // Handshake: a group transfers on any cycle where out_valid && out_ready;
    // out_data is held unchanged while out_valid && !out_ready.

    state_t              state;
    logic [LANES*OW-1:0] acc;
    logic [LANES*OW-1:0] sum;
    logic [LANES*OW-1:0] out_next;
    logic [LANES*PW-1:0] lane_in;
    logic [2:0]          cnt;
    logic [2:0]          rounds;
    logic [2:0]          cnt_next;
    logic [2:0]          rounds_eff;
    rounds_t             wcode;
    logic                load;
    logic                fire;
    logic                out_free;
    logic                last;

    assign wcode      = rounds_of(wsize);
    assign load       = (state == IDLE);
    assign fire       = out_valid && out_ready;
    assign out_free   = !out_valid || out_ready;
    assign cnt_next   = load ? 3'd1 : cnt + 3'd1;
    assign rounds_eff = load ? wcode.rounds : rounds;
    assign last       = (cnt_next == rounds_eff);
    assign busy       = (state != IDLE);

    // In STALL the lanes add zero, so out_next is the held group after optional ReLU.
    assign lane_in = (state == STALL) ? '0 : Psum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psum_lane_add u_lane (
            .psum    (lane_in[i*PW +: PW]),
            .acc     (acc[i*OW +: OW]),
            .load    (load),
            .sum     (sum[i*OW +: OW]),
            .out_val (out_next[i*OW +: OW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= 3'd0;
            rounds    <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            bad_wsize <= 1'b0;
        end else begin
            if (fire) begin
                out_valid <= 1'b0;
            end
            if (state == STALL) begin
                if (Psum_valid) begin
                    overflow <= 1'b1;
                end
                if (fire) begin
                    out_data  <= out_next;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end else if (Psum_valid) begin
                if (state == IDLE) begin
                    rounds <= wcode.rounds;
                    if (wcode.illegal) begin
                        bad_wsize <= 1'b1;
                    end
                end
                if (!last) begin
                    acc   <= sum;
                    cnt   <= cnt_next;
                    state <= ACCUM;
                end else if (out_free) begin
                    out_data  <= out_next;
                    out_valid <= 1'b1;
                    cnt       <= 3'd0;
                    state     <= IDLE;
                end else begin
                    acc   <= sum;
                    cnt   <= 3'd0;
                    state <= STALL;
                end
            end
        end
    end

endmodule
